// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  // RUN: normal hazard evaluation; MEM_WAIT: data memory holding the MEM stage.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

  // Register $zero never carries a real dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // The wait-state counter is 4 bits wide, so latencies above 15 cannot be counted.
  localparam int WCNT_W      = 4;
  localparam int MEM_LAT_MAX = 15;

  function automatic bit mem_latency_ok(input int lat);
    return (lat >= 0) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the ID instruction needs a register that the
// load currently in EX has not yet produced.
module load_use_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_WriteRegister,
  output logic             hazard
);

  logic dest_live;
  logic rs_match;
  logic rt_match;

  // A load into $zero produces nothing, so it cannot cause a hazard.
  always_comb begin
    dest_live = (EX_WriteRegister != REG_W'(REG_ZERO));
    rs_match  = (EX_WriteRegister == ID_rs);
    rt_match  = ID_UsesRt && (EX_WriteRegister == ID_rt);
    hazard    = EX_MemRead && dest_live && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: memory wait states,
// load-use stalls, and branch/jump flushes, plus a saturating stall counter.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int REG_W       = 5,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_WriteRegister,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  output logic             PC_Enable,
  output logic             Enable_IF_ID,
  output logic             Flush_IF_ID,
  output logic             Enable_ID_EX,
  output logic             Flush_ID_EX,
  output logic             Enable_EX_MEM,
  output logic             Enable_MEM_WB,
  output logic             MemBusy,
  output logic [CNT_W-1:0] Stall_Cycles
);

  if (!mem_latency_ok(MEM_LATENCY)) begin : g_bad_latency
    $error("pipeline_stall_ctrl: MEM_LATENCY must be within 0..15");
  end

  localparam bit                HAS_WAIT  = (MEM_LATENCY > 0);
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(MEM_LATENCY - 1);

  ctrl_state_e       state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_acc;
  logic              freeze;
  logic              load_use;

  assign mem_acc = MEM_MemRead || MEM_MemWrite;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use (
    .ID_rs            (ID_rs),
    .ID_rt            (ID_rt),
    .ID_UsesRt        (ID_UsesRt),
    .EX_MemRead       (EX_MemRead),
    .EX_WriteRegister (EX_WriteRegister),
    .hazard           (load_use)
  );

  // Wait-state FSM next state; the release cycle always returns to RUN so the
  // access that was just served cannot retrigger a wait.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    freeze  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (HAS_WAIT && mem_acc) begin
          freeze  = 1'b1;
          wcnt_d  = WCNT_LOAD;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (wcnt_q != '0) begin
          freeze = 1'b1;
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // Priority mux: reset, memory freeze, taken branch, load-use, jump.
  always_comb begin
    PC_Enable     = 1'b1;
    Enable_IF_ID  = 1'b1;
    Flush_IF_ID   = 1'b0;
    Enable_ID_EX  = 1'b1;
    Flush_ID_EX   = 1'b0;
    Enable_EX_MEM = 1'b1;
    Enable_MEM_WB = 1'b1;
    MemBusy       = 1'b0;
    if (reset) begin
      PC_Enable     = 1'b0;
      Enable_IF_ID  = 1'b0;
      Enable_ID_EX  = 1'b0;
      Enable_EX_MEM = 1'b0;
      Enable_MEM_WB = 1'b0;
    end else if (freeze) begin
      PC_Enable     = 1'b0;
      Enable_IF_ID  = 1'b0;
      Enable_ID_EX  = 1'b0;
      Enable_EX_MEM = 1'b0;
      Enable_MEM_WB = 1'b0;
      MemBusy       = 1'b1;
    end else if (EX_BranchTaken) begin
      Flush_IF_ID = 1'b1;
      Flush_ID_EX = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX; a pending jump waits.
      PC_Enable    = 1'b0;
      Enable_IF_ID = 1'b0;
      Flush_ID_EX  = 1'b1;
    end else if (ID_Jump) begin
      Flush_IF_ID = 1'b1;
    end
  end

  // State, wait counter and saturating stall counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= RUN;
      wcnt_q       <= '0;
      Stall_Cycles <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (!PC_Enable && (Stall_Cycles != '1)) begin
        Stall_Cycles <= Stall_Cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: three builds (MEM_LATENCY 2, 0 and
// 3 with a 4-bit stall counter) share stimulus; each scenario targets one build.
module tb_pipeline_stall_ctrl;

  // Output vector order: {PC, IF/ID en, IF/ID flush, ID/EX en, ID/EX flush,
  //                       EX/MEM en, MEM/WB en, MemBusy}
  localparam logic [7:0] C_RST    = 8'b0000_0000;
  localparam logic [7:0] C_NORMAL = 8'b1101_0110;
  localparam logic [7:0] C_FREEZE = 8'b0000_0001;
  localparam logic [7:0] C_LU     = 8'b0001_1110;
  localparam logic [7:0] C_BRANCH = 8'b1111_1110;
  localparam logic [7:0] C_JUMP   = 8'b1111_0110;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       jump;
    logic       ex_mr;
    logic [4:0] ex_wr;
    logic       br;
    logic       mem_r;
    logic       mem_w;
  } stim_t;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] ctl;
    int         stall;   // -1: counter value not yet known
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] ID_rs = '0, ID_rt = '0, EX_WriteRegister = '0;
  logic       ID_UsesRt = 1'b0, ID_Jump = 1'b0, EX_MemRead = 1'b0;
  logic       EX_BranchTaken = 1'b0, MEM_MemRead = 1'b0, MEM_MemWrite = 1'b0;

  logic [7:0]  ctl [3];
  logic [15:0] stall_a, stall_b;
  logic [3:0]  stall_c;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_stall = 0;
  int   cur_sel = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MEM_LATENCY(2), .REG_W(5), .CNT_W(16)) dut_l2 (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister),
    .EX_BranchTaken(EX_BranchTaken), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .PC_Enable(ctl[0][7]), .Enable_IF_ID(ctl[0][6]), .Flush_IF_ID(ctl[0][5]),
    .Enable_ID_EX(ctl[0][4]), .Flush_ID_EX(ctl[0][3]), .Enable_EX_MEM(ctl[0][2]),
    .Enable_MEM_WB(ctl[0][1]), .MemBusy(ctl[0][0]), .Stall_Cycles(stall_a));

  pipeline_stall_ctrl #(.MEM_LATENCY(0), .REG_W(5), .CNT_W(16)) dut_l0 (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister),
    .EX_BranchTaken(EX_BranchTaken), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .PC_Enable(ctl[1][7]), .Enable_IF_ID(ctl[1][6]), .Flush_IF_ID(ctl[1][5]),
    .Enable_ID_EX(ctl[1][4]), .Flush_ID_EX(ctl[1][3]), .Enable_EX_MEM(ctl[1][2]),
    .Enable_MEM_WB(ctl[1][1]), .MemBusy(ctl[1][0]), .Stall_Cycles(stall_b));

  pipeline_stall_ctrl #(.MEM_LATENCY(3), .REG_W(5), .CNT_W(4)) dut_l3 (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_WriteRegister(EX_WriteRegister),
    .EX_BranchTaken(EX_BranchTaken), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .PC_Enable(ctl[2][7]), .Enable_IF_ID(ctl[2][6]), .Flush_IF_ID(ctl[2][5]),
    .Enable_ID_EX(ctl[2][4]), .Flush_ID_EX(ctl[2][3]), .Enable_EX_MEM(ctl[2][2]),
    .Enable_MEM_WB(ctl[2][1]), .MemBusy(ctl[2][0]), .Stall_Cycles(stall_c));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic stim_t s_idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Drive one cycle of stimulus and queue the outputs it must produce.
  task automatic step(input string tag, input stim_t s, input logic [7:0] exp_ctl);
    exp_t e;
    int   sat;
    @(posedge clk);
    #1;
    reset            = s.rst;
    ID_rs            = s.rs;
    ID_rt            = s.rt;
    ID_UsesRt        = s.uses_rt;
    ID_Jump          = s.jump;
    EX_MemRead       = s.ex_mr;
    EX_WriteRegister = s.ex_wr;
    EX_BranchTaken   = s.br;
    MEM_MemRead      = s.mem_r;
    MEM_MemWrite     = s.mem_w;
    e.tag   = tag;
    e.sel   = cur_sel;
    e.ctl   = exp_ctl;
    e.stall = exp_stall;
    sb.push_back(e);
    sat = (cur_sel == 2) ? 15 : 65535;
    if (s.rst) exp_stall = 0;
    else if (!exp_ctl[7] && exp_stall < sat) exp_stall++;
  endtask

  // Begin a scenario on one build with a reset cycle.
  task automatic start(input int sel);
    stim_t s;
    cur_sel   = sel;
    exp_stall = -1;
    s = s_idle();
    s.rst = 1'b1;
    step("reset", s, C_RST);
  endtask

  // Compare DUT outputs against the scoreboard, away from the active edge.
  exp_t        mon_e;
  logic [15:0] mon_stall;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      case (mon_e.sel)
        0:       mon_stall = stall_a;
        1:       mon_stall = stall_b;
        default: mon_stall = {12'd0, stall_c};
      endcase
      check({mon_e.tag, "/ctl"}, 32'(ctl[mon_e.sel]), 32'(mon_e.ctl));
      if (mon_e.stall >= 0) check({mon_e.tag, "/stall"}, 32'(mon_stall), 32'(mon_e.stall));
    end
  end

  initial begin
    stim_t s;
    repeat (2) @(posedge clk);

    // ---------------- MEM_LATENCY = 2 build ----------------
    start(0);
    step("idle", s_idle(), C_NORMAL);
    s = s_idle(); s.ex_mr = 1; s.ex_wr = 5'd8; s.rs = 5'd8;
    step("lu_rs", s, C_LU);
    step("after_lu", s_idle(), C_NORMAL);
    s = s_idle(); s.ex_mr = 1; s.ex_wr = 5'd9; s.rt = 5'd9; s.uses_rt = 1; s.rs = 5'd3;
    step("lu_rt", s, C_LU);
    s = s_idle(); s.ex_mr = 1; s.ex_wr = 5'd0; s.rs = 5'd0;
    step("zero_reg", s, C_NORMAL);
    s = s_idle(); s.ex_mr = 1; s.ex_wr = 5'd8; s.rt = 5'd8; s.uses_rt = 0; s.rs = 5'd3;
    step("rt_unused", s, C_NORMAL);
    s = s_idle(); s.ex_mr = 0; s.ex_wr = 5'd8; s.rs = 5'd8;
    step("not_load", s, C_NORMAL);
    s = s_idle(); s.ex_mr = 1; s.ex_wr = 5'd8; s.rs = 5'd8; s.br = 1;
    step("br_over_lu", s, C_BRANCH);
    s = s_idle(); s.ex_mr = 1; s.ex_wr = 5'd8; s.rs = 5'd8; s.jump = 1;
    step("lu_over_jump", s, C_LU);
    s = s_idle(); s.jump = 1;
    step("jump", s, C_JUMP);

    s = s_idle(); s.mem_r = 1;
    step("mem_w1", s, C_FREEZE);
    step("mem_w2", s, C_FREEZE);
    step("mem_rel", s, C_NORMAL);
    step("mem_idle", s_idle(), C_NORMAL);

    s = s_idle(); s.mem_r = 1;
    for (int i = 0; i < 6; i++) step("b2b", s, (i % 3 == 2) ? C_NORMAL : C_FREEZE);

    s = s_idle(); s.mem_w = 1; s.br = 1;
    step("memw_br1", s, C_FREEZE);
    step("memw_br2", s, C_FREEZE);
    step("memw_br_rel", s, C_BRANCH);

    s = s_idle(); s.mem_r = 1; s.ex_mr = 1; s.ex_wr = 5'd4; s.rt = 5'd4; s.uses_rt = 1;
    step("mem_lu1", s, C_FREEZE);
    step("mem_lu2", s, C_FREEZE);
    step("mem_lu_rel", s, C_LU);
    step("tail_l2", s_idle(), C_NORMAL);

    // ---------------- MEM_LATENCY = 0 build ----------------
    start(1);
    s = s_idle(); s.mem_r = 1;
    step("l0_mem1", s, C_NORMAL);
    step("l0_mem2", s, C_NORMAL);
    s.ex_mr = 1; s.ex_wr = 5'd7; s.rs = 5'd7;
    step("l0_mem_lu", s, C_LU);
    step("tail_l0", s_idle(), C_NORMAL);

    // ---------------- MEM_LATENCY = 3, 4-bit counter build ----------------
    start(2);
    s = s_idle(); s.mem_r = 1;
    step("l3_w1", s, C_FREEZE);
    step("l3_w2", s, C_FREEZE);
    s.rst = 1;
    step("l3_rst_mid", s, C_RST);
    step("l3_after_rst", s_idle(), C_NORMAL);
    s = s_idle(); s.mem_r = 1;
    for (int i = 0; i < 4; i++) step("l3_occ", s, (i == 3) ? C_NORMAL : C_FREEZE);
    step("l3_idle", s_idle(), C_NORMAL);
    for (int i = 0; i < 24; i++) step("l3_sat", s, (i % 4 == 3) ? C_NORMAL : C_FREEZE);
    step("l3_sat_hold1", s_idle(), C_NORMAL);
    step("l3_sat_hold2", s_idle(), C_NORMAL);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
